// File: rtl/next_audio_op_engine.sv
`default_nettype none
// ============================================================================
//  Module   : next_audio_op_engine
//  Brief    : Decodes NeXT soundbox/keyboard ops into registered control state
//             and plays buffered C7 samples out on a valid/ready stream.
//  Revision : 1.0 - initial release
// ============================================================================
module next_audio_op_engine #(
    parameter int FIFO_AW  = 4,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [23:0]         op,
    input  logic                op_valid,
    output logic [SAMPLE_W-1:0] smp_data,
    output logic                smp_valid,
    input  logic                smp_ready,
    output logic                audio_running,
    output logic                audio_22khz,
    output logic                audio_repeat,
    output logic [7:0]          atten,
    output logic                atten_update,
    output logic [7:0]          kbd_led,
    output logic                kbd_led_update,
    output logic                power_on,
    output logic                mic_active,
    output logic [FIFO_AW:0]    fifo_level,
    output logic                overflow,
    output logic                underrun
);

    localparam int               DEPTH    = 2**FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [FIFO_AW:0]    wr_q, wr_d, rd_q, rd_d;
    logic [1:0]          state_q, state_d;
    logic                phase_q, phase_d;
    logic                rep_beat_q, rep_beat_d;
    logic                a22_q, a22_d, arep_q, arep_d;
    logic [7:0]          atten_q, atten_d, led_q, led_d;
    logic                atten_upd_q, atten_upd_d, led_upd_q, led_upd_d;
    logic                pwr_q, pwr_d, mic_q, mic_d;
    logic                ovf_q, ovf_d, unr_q, unr_d;

    logic [7:0] opc, data1, data2;
    logic       empty, full, fire, pop, push;
    logic       is_pwr, is_led, is_atten, is_smp, is_mic_on, is_mic_off, is_flush, is_audio;

    assign opc   = op[23:16];
    assign data1 = op[15:8];
    assign data2 = op[7:0];

    assign is_pwr     = op_valid && opc == 8'hC5 && data1 == 8'hEF;
    assign is_led     = op_valid && opc == 8'hC5 && data1 == 8'h00;
    assign is_atten   = op_valid && opc == 8'hC4 && data2 == 8'h00;
    assign is_smp     = op_valid && opc == 8'hC7;
    assign is_mic_on  = op_valid && opc[7:6] == 2'b00 && opc[3:0] == 4'b1011;
    assign is_mic_off = op_valid && opc[7:6] == 2'b00 && opc[3:0] == 4'b0011;
    assign is_flush   = op_valid && opc == 8'hFF;
    assign is_audio   = op_valid && opc[7:6] == 2'b00 && opc[2:0] == 3'b111;

    assign fifo_level = wr_q - rd_q;
    assign empty      = (wr_q == rd_q);
    assign full       = (fifo_level == FULL_LVL);
    assign smp_valid  = (state_q != ST_IDLE) && !empty;
    assign fire       = smp_valid && smp_ready;
    // In 22 kHz mode the entry is only consumed on the second beat of the pair
    assign pop        = fire && (phase_q || !a22_q);
    assign push       = is_smp && (!full || pop);

    always_comb begin
        if (!smp_valid || (phase_q && !rep_beat_q)) begin
            smp_data = '0;
        end else begin
            smp_data = mem_q[rd_q[FIFO_AW-1:0]];
        end
    end

    always_comb begin
        wr_d        = wr_q + (FIFO_AW+1)'(push);
        rd_d        = rd_q + (FIFO_AW+1)'(pop);
        state_d     = state_q;
        phase_d     = phase_q;
        rep_beat_d  = rep_beat_q;
        a22_d       = a22_q;
        arep_d      = arep_q;
        atten_d     = atten_q;
        led_d       = led_q;
        atten_upd_d = 1'b0;
        led_upd_d   = 1'b0;
        pwr_d       = 1'b0;
        mic_d       = mic_q;
        ovf_d       = ovf_q || (is_smp && !push);
        unr_d       = unr_q || (state_q == ST_RUN && smp_ready && empty);

        // Repeat/zero-fill choice is frozen at the first beat of a pair
        if (fire) begin
            if (phase_q) begin
                phase_d = 1'b0;
            end else if (a22_q) begin
                phase_d    = 1'b1;
                rep_beat_d = arep_q;
            end
        end

        if (state_q == ST_DRAIN && empty && !phase_q) begin
            state_d = ST_IDLE;
        end

        if (is_pwr) begin
            pwr_d = 1'b1;
        end else if (is_led) begin
            led_d     = data2;
            led_upd_d = 1'b1;
        end else if (is_atten) begin
            atten_d     = data1;
            atten_upd_d = 1'b1;
        end else if (is_mic_on) begin
            mic_d = 1'b1;
        end else if (is_mic_off) begin
            mic_d = 1'b0;
        end else if (is_flush) begin
            wr_d    = '0;
            rd_d    = '0;
            state_d = ST_IDLE;
            phase_d = 1'b0;
            ovf_d   = 1'b0;
            unr_d   = 1'b0;
            mic_d   = 1'b0;
        end else if (is_audio) begin
            a22_d  = opc[4];
            arep_d = ~opc[5];
            if (opc[3]) begin
                state_d = ST_RUN;
            end else if (state_q == ST_RUN) begin
                state_d = ST_DRAIN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q        <= '0;
            rd_q        <= '0;
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            rep_beat_q  <= 1'b0;
            a22_q       <= 1'b0;
            arep_q      <= 1'b0;
            atten_q     <= '0;
            led_q       <= '0;
            atten_upd_q <= 1'b0;
            led_upd_q   <= 1'b0;
            pwr_q       <= 1'b0;
            mic_q       <= 1'b0;
            ovf_q       <= 1'b0;
            unr_q       <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            state_q     <= state_d;
            phase_q     <= phase_d;
            rep_beat_q  <= rep_beat_d;
            a22_q       <= a22_d;
            arep_q      <= arep_d;
            atten_q     <= atten_d;
            led_q       <= led_d;
            atten_upd_q <= atten_upd_d;
            led_upd_q   <= led_upd_d;
            pwr_q       <= pwr_d;
            mic_q       <= mic_d;
            ovf_q       <= ovf_d;
            unr_q       <= unr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[FIFO_AW-1:0]] <= op[SAMPLE_W-1:0];
        end
    end

    assign audio_running  = (state_q != ST_IDLE);
    assign audio_22khz    = a22_q;
    assign audio_repeat   = arep_q;
    assign atten          = atten_q;
    assign atten_update   = atten_upd_q;
    assign kbd_led        = led_q;
    assign kbd_led_update = led_upd_q;
    assign power_on       = pwr_q;
    assign mic_active     = mic_q;
    assign overflow       = ovf_q;
    assign underrun       = unr_q;

endmodule
`default_nettype wire
